// File: rtl/cla_add_arbiter_pkg.sv
// Shared types and constants for the two-requester 5-bit CLA add arbiter.
package cla_pkg;

    localparam int CLA_W = 5;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef struct packed {
        logic             id;
        logic [CLA_W-1:0] a;
        logic [CLA_W-1:0] b;
    } op_t;

endpackage

// File: rtl/cla_add_arbiter_cla5_core.sv
// Purely combinational 5-bit carry-lookahead adder with flattened carry equations.
module cla5_core
    import cla_pkg::*;
(
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             cin,
    output logic [CLA_W-1:0] sum,
    output logic             cout
);

    logic [CLA_W-1:0] p_s;
    logic [CLA_W-1:0] g_s;
    logic [CLA_W:0]   c_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Every carry is a two-level sum of products, no ripple through lower bits
    assign c_s[0] = cin;
    assign c_s[1] = g_s[0] | (p_s[0] & cin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cin);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
    assign c_s[5] = g_s[4] | (p_s[4] & g_s[3]) | (p_s[4] & p_s[3] & g_s[2])
                  | (p_s[4] & p_s[3] & p_s[2] & g_s[1])
                  | (p_s[4] & p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[4] & p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

    assign sum  = p_s ^ c_s[CLA_W-1:0];
    assign cout = c_s[CLA_W];

endmodule

// File: rtl/cla_add_arbiter.sv
// Round-robin arbiter sharing one registered CLA add pipeline between two requesters;
// results come back two clocks after acceptance, tagged with the issuing requester.
module cla_add_arbiter
    import cla_pkg::*;
#(
    parameter int W     = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_sum,
    output logic             rsp_cout,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             busy
);

    logic             ptr_r;
    logic             grant_ok_s;
    logic             winner_s;
    logic             xfer_s;
    op_t              op_in_s;
    op_t              op1_r;
    logic             v1_r;
    logic             v2_r;
    logic             rsp_id_r;
    logic [W-1:0]     rsp_sum_r;
    logic             rsp_cout_r;
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;
    logic [W-1:0]     core_sum_s;
    logic             core_cout_s;

    // Winner selection; with nobody valid the pointer's requester is offered ready
    always_comb begin
        grant_ok_s = en & ~flush;
        if (req0_valid && req1_valid) begin
            winner_s = ptr_r;
        end else if (req1_valid) begin
            winner_s = REQ1;
        end else if (req0_valid) begin
            winner_s = REQ0;
        end else begin
            winner_s = ptr_r;
        end
    end

    // Operand mux and transfer qualification for the winning requester
    always_comb begin
        op_in_s.id = winner_s;
        if (winner_s == REQ1) begin
            op_in_s.a = req1_a;
            op_in_s.b = req1_b;
            xfer_s    = grant_ok_s & req1_valid;
        end else begin
            op_in_s.a = req0_a;
            op_in_s.b = req0_b;
            xfer_s    = grant_ok_s & req0_valid;
        end
    end

    assign req0_ready = grant_ok_s & (winner_s == REQ0);
    assign req1_ready = grant_ok_s & (winner_s == REQ1);

    // Round-robin pointer: hand priority to the loser after every transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= REQ0;
        end else if (xfer_s) begin
            ptr_r <= ~winner_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Stage 1: operand capture; data holds when nothing is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r  <= 1'b0;
            op1_r <= '0;
        end else if (flush) begin
            v1_r  <= 1'b0;
        end else if (xfer_s) begin
            v1_r  <= 1'b1;
            op1_r <= op_in_s;
        end else begin
            v1_r  <= 1'b0;
        end
    end

    cla5_core u_core (
        .a    (op1_r.a),
        .b    (op1_r.b),
        .cin  (1'b0),
        .sum  (core_sum_s),
        .cout (core_cout_s)
    );

    // Stage 2: result capture; result registers keep the last answer when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r       <= 1'b0;
            rsp_id_r   <= REQ0;
            rsp_sum_r  <= '0;
            rsp_cout_r <= 1'b0;
        end else if (flush) begin
            v2_r       <= 1'b0;
        end else if (v1_r) begin
            v2_r       <= 1'b1;
            rsp_id_r   <= op1_r.id;
            rsp_sum_r  <= core_sum_s;
            rsp_cout_r <= core_cout_s;
        end else begin
            v2_r       <= 1'b0;
        end
    end

    // Completion counters count every presented response and wrap silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= '0;
            cnt1_r <= '0;
        end else if (v2_r) begin
            if (rsp_id_r == REQ1) begin
                cnt1_r <= cnt1_r + CNT_W'(1);
            end else begin
                cnt0_r <= cnt0_r + CNT_W'(1);
            end
        end else begin
            cnt0_r <= cnt0_r;
            cnt1_r <= cnt1_r;
        end
    end

    assign rsp_valid = v2_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_sum   = rsp_sum_r;
    assign rsp_cout  = rsp_cout_r;
    assign cnt0      = cnt0_r;
    assign cnt1      = cnt1_r;
    assign busy      = v1_r | v2_r;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Scoreboard bench: driver predicts grants and queues expected results, monitor checks them.
module tb_cla_add_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic       req0_valid = 1'b0;
    logic [4:0] req0_a = 5'd0;
    logic [4:0] req0_b = 5'd0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [4:0] req1_a = 5'd0;
    logic [4:0] req1_b = 5'd0;
    logic       req1_ready;
    logic       rsp_valid;
    logic       rsp_id;
    logic [4:0] rsp_sum;
    logic       rsp_cout;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic       busy;

    cla_add_arbiter #(.W(5), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [4:0] a;
        logic [4:0] b;
        int         acc_edge;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   edge_n = 0;
    logic ptr_m = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // One clock of stimulus; the model decides the grant from the arbitration rules
    task automatic cycle(input logic v0, input logic [4:0] a0, input logic [4:0] b0,
                         input logic v1, input logic [4:0] a1, input logic [4:0] b1,
                         input logic e, input logic f);
        logic can;
        logic win;
        logic xfer;
        exp_t ent;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        en = e; flush = f;
        @(negedge clk);
        can  = e && !f;
        win  = (v0 && v1) ? ptr_m : v1;
        xfer = can && (v0 || v1);
        if (v0 || !can) chk("req0_ready", int'(req0_ready), int'(can && v0 && !win));
        if (v1 || !can) chk("req1_ready", int'(req1_ready), int'(can && v1 && win));
        chk("ready_exclusive", int'(req0_ready && req1_ready), 0);
        @(posedge clk);
        edge_n++;
        if (f) begin
            while (q.size() > 0 && q[$].acc_edge >= edge_n - 1) void'(q.pop_back());
        end
        if (xfer) begin
            ent.id = win;
            ent.a  = win ? a1 : a0;
            ent.b  = win ? b1 : b0;
            ent.acc_edge = edge_n;
            q.push_back(ent);
            ptr_m = ~win;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock
    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        chk("rst_rsp_sum", int'(rsp_sum), 0);
        chk("rst_rsp_cout", int'(rsp_cout), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        q.delete();
        ptr_m = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; en = 1'b0; flush = 1'b0;
        repeat (2) begin
            @(posedge clk);
            edge_n++;
        end
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compares every presented response against the queued expectation
    initial begin : monitor
        logic [7:0] mc0;
        logic [7:0] mc1;
        logic [4:0] last_sum;
        logic       last_cout;
        logic [5:0] s6;
        exp_t       e;
        mc0 = 8'd0; mc1 = 8'd0; last_sum = 5'd0; last_cout = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mc0 = 8'd0; mc1 = 8'd0; last_sum = 5'd0; last_cout = 1'b0;
            end else begin
                chk("busy", int'(busy), int'(q.size() != 0));
                chk("cnt0", int'(cnt0), int'(mc0));
                chk("cnt1", int'(cnt1), int'(mc1));
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_rsp", 1, 0);
                    end else begin
                        e  = q.pop_front();
                        s6 = {1'b0, e.a} + {1'b0, e.b};
                        chk("rsp_id", int'(rsp_id), int'(e.id));
                        chk("rsp_sum", int'(rsp_sum), int'(s6[4:0]));
                        chk("rsp_cout", int'(rsp_cout), int'(s6[5]));
                        chk("latency", edge_n, e.acc_edge + 1);
                        if (e.id) mc1 = mc1 + 8'd1;
                        else      mc0 = mc0 + 8'd1;
                        last_sum  = s6[4:0];
                        last_cout = s6[5];
                    end
                end else begin
                    chk("sum_hold", int'(rsp_sum), int'(last_sum));
                    chk("cout_hold", int'(rsp_cout), int'(last_cout));
                    if (q.size() > 0 && q[0].acc_edge + 1 <= edge_n) begin
                        chk("missing_rsp", 0, 1);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : driver
        @(posedge clk);
        #1;
        async_reset();

        // single op: 19+14 = 33 -> sum 1, cout 1
        cycle(1'b1, 5'd19, 5'd14, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
        idle(4);

        // contention straight out of reset: grants alternate starting with requester 0
        async_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 5'd3, 5'd4, 1'b1, 5'd10, 5'd21, 1'b1, 1'b0);
        idle(3);

        // carry extremes on requester 1
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 5'd31, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0);
        idle(3);

        // flush with requests still pending: readys low, op in stage 1 is dropped
        cycle(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd8, 1'b1, 1'b0);
        cycle(1'b1, 5'd9, 5'd9, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1);
        idle(3);

        // en low blocks acceptance; raising it grants on the next cycle
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd12, 5'd17, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'd12, 5'd17, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
        idle(3);

        // reset with both stages full, then first contested grant goes to requester 0
        cycle(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 5'd4, 1'b1, 1'b0);
        chk("busy_before_reset", int'(busy), 1);
        async_reset();
        cycle(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 5'd6, 1'b1, 1'b0);
        idle(3);

        // randomized traffic with occasional en drops and flushes
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                  1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                  1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0));
        end
        idle(3);

        // long requester-0 stream to push cnt0 through its wrap
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 5'($urandom), 5'($urandom), 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
        end
        idle(4);

        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
